// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int REG_AW_DEF   = 5;
  localparam int CNT_W_DEF    = 32;
  localparam int MAX_WAIT_DEF = 1023;

  localparam logic [REG_AW_DEF-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments when enabled, sticks at all ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: hold when idle or already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: memory freeze > load-use bubble > branch flush,
// plus saturating stall statistics and a sticky memory-timeout flag.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memread_i,
  input  logic              branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_bubble_o,
  output logic              pipe_freeze_o,
  output logic [CNT_W-1:0]  mem_stall_cnt_o,
  output logic [CNT_W-1:0]  load_use_cnt_o,
  output logic              mem_timeout_o
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              run_s, mem_miss_s, load_use_s;

  // Hazard decode; reset gates the controls combinationally so they drop without a clock.
  always_comb begin
    run_s      = rst_i & start_i;
    mem_miss_s = mem_req_i & ~mem_ack_i;
    load_use_s = ex_memread_i & (ex_rd_i != REG_AW'(REG_ZERO)) &
                 ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
  end

  // Prioritized control outputs.
  always_comb begin
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    pipe_freeze_o  = 1'b0;
    if (!run_s) begin
      pipe_freeze_o = 1'b0;
    end else if (mem_miss_s) begin
      pipe_freeze_o = 1'b1;
    end else if (load_use_s) begin
      id_ex_bubble_o = 1'b1;
    end else begin
      pc_write_o    = 1'b1;
      if_id_write_o = 1'b1;
      if_id_flush_o = branch_taken_i;
    end
  end

  // Memory-wait FSM, wait counter and timeout flag; everything holds while stopped.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (start_i) begin
      case (state_q)
        RUN: begin
          if (mem_miss_s) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = '0;
          end else begin
            state_d = RUN;
          end
        end
        MEM_WAIT: begin
          if (!mem_miss_s) begin
            state_d = RUN;
          end else begin
            // The counter parks at MAX_WAIT; the flag is sticky so nothing is lost.
            if (wait_cnt_q != WAIT_MAX) begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else begin
              wait_cnt_d = wait_cnt_q;
            end
            if (wait_cnt_d == WAIT_MAX) begin
              timeout_d = 1'b1;
            end else begin
              timeout_d = timeout_q;
            end
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, wait counter and flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout_o = timeout_q;

  sat_counter #(.W(CNT_W)) u_mem_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (pipe_freeze_o),
    .cnt_o  (mem_stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_load_use_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (id_ex_bubble_o),
    .cnt_o  (load_use_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected outputs queued per driven cycle and checked mid-cycle.
module tb_hazard_ctrl;

  localparam int REG_AW   = 5;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 8;

  // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] BR   = 5'b11100;
  localparam logic [4:0] LU   = 5'b00010;
  localparam logic [4:0] FRZ  = 5'b00001;
  localparam logic [4:0] OFF  = 5'b00000;

  typedef struct {
    logic [4:0]       ctl;
    logic             to;
    logic [CNT_W-1:0] mcnt;
    logic [CNT_W-1:0] lcnt;
    string            tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic              ex_memread_i, branch_taken_i, mem_req_i, mem_ack_i;
  logic              pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, pipe_freeze_o;
  logic [CNT_W-1:0]  mem_stall_cnt_o, load_use_cnt_o;
  logic              mem_timeout_o;

  int               checks = 0;
  int               errors = 0;
  exp_t             sb_q[$];
  logic [CNT_W-1:0] mcnt_m, lcnt_m;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .ex_rd_i         (ex_rd_i),
    .ex_memread_i    (ex_memread_i),
    .branch_taken_i  (branch_taken_i),
    .mem_req_i       (mem_req_i),
    .mem_ack_i       (mem_ack_i),
    .pc_write_o      (pc_write_o),
    .if_id_write_o   (if_id_write_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_bubble_o  (id_ex_bubble_o),
    .pipe_freeze_o   (pipe_freeze_o),
    .mem_stall_cnt_o (mem_stall_cnt_o),
    .load_use_cnt_o  (load_use_cnt_o),
    .mem_timeout_o   (mem_timeout_o)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, pipe_freeze_o}, 32'd0);
    chk({tag, "_to"}, {31'd0, mem_timeout_o}, 32'd0);
    chk({tag, "_mcnt"}, {28'd0, mem_stall_cnt_o}, 32'd0);
    chk({tag, "_lcnt"}, {28'd0, load_use_cnt_o}, 32'd0);
  endtask

  // One clock cycle: drive at posedge+1, queue expectation, check at posedge+5, advance.
  task automatic cyc(input logic st, input logic rq, input logic ak, input logic mr, input logic br,
                     input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2,
                     input logic [4:0] ectl, input logic eto, input string tag);
    exp_t e;
    start_i = st; mem_req_i = rq; mem_ack_i = ak; ex_memread_i = mr; branch_taken_i = br;
    ex_rd_i = rd; id_rs1_i = r1; id_rs2_i = r2;
    sb_q.push_back('{ctl: ectl, to: eto, mcnt: mcnt_m, lcnt: lcnt_m, tag: tag});
    #4;
    e = sb_q.pop_front();
    chk({e.tag, "_ctl"}, {27'd0, pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, pipe_freeze_o},
        {27'd0, e.ctl});
    chk({e.tag, "_to"}, {31'd0, mem_timeout_o}, {31'd0, e.to});
    chk({e.tag, "_mcnt"}, {28'd0, mem_stall_cnt_o}, {28'd0, e.mcnt});
    chk({e.tag, "_lcnt"}, {28'd0, load_use_cnt_o}, {28'd0, e.lcnt});
    mcnt_m = sat_inc(mcnt_m, ectl[0]);
    lcnt_m = sat_inc(lcnt_m, ectl[1]);
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic rq, input logic ak, input logic [4:0] ectl, input logic eto, input string tag);
    cyc(1'b1, rq, ak, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ectl, eto, tag);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
    ex_memread_i = 1'b0; branch_taken_i = 1'b0;
    ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    mcnt_m = '0; lcnt_m = '0;
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_i = 1'b1;

    // Basic hazards
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, NORM, 1'b0, "idle");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, BR,   1'b0, "branch");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd3, 5'd5, LU,   1'b0, "load_use");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd3, 5'd5, NORM, 1'b0, "lu_after");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, NORM, 1'b0, "rd_zero");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, NORM, 1'b0, "no_load");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd2, LU,   1'b0, "br_plus_lu");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd2, FRZ,  1'b0, "br_lu_miss");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd2, LU,   1'b0, "release_lu");

    // Miss at t, ack at t+4: four freeze cycles
    for (int i = 0; i < 4; i++) mem(1'b1, 1'b0, FRZ, 1'b0, "miss_wait");
    mem(1'b1, 1'b1, NORM, 1'b0, "miss_ack");
    mem(1'b0, 1'b0, NORM, 1'b0, "miss_done");
    mem(1'b1, 1'b1, NORM, 1'b0, "same_cyc_ack");

    // Abort and start_i=0 during a wait
    mem(1'b1, 1'b0, FRZ, 1'b0, "abort_miss");
    mem(1'b0, 1'b0, NORM, 1'b0, "abort");
    mem(1'b1, 1'b0, FRZ, 1'b0, "stop_miss");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, OFF, 1'b0, "stopped");
    mem(1'b1, 1'b0, FRZ, 1'b0, "resumed");
    mem(1'b1, 1'b1, NORM, 1'b0, "resume_ack");

    // Timeout; the stall counter also saturates along the way
    for (int i = 0; i < 9; i++) mem(1'b1, 1'b0, FRZ, 1'b0, "to_wait");
    mem(1'b1, 1'b0, FRZ, 1'b1, "to_set");
    mem(1'b1, 1'b1, NORM, 1'b1, "to_ack");
    mem(1'b0, 1'b0, NORM, 1'b1, "to_sticky");

    // Asynchronous reset in the middle of MEM_WAIT
    mem(1'b1, 1'b0, FRZ, 1'b1, "pre_rst_a");
    mem(1'b1, 1'b0, FRZ, 1'b1, "pre_rst_b");
    #6;
    rst_i = 1'b0;
    #1;
    chk_all_zero("async_rst");
    mcnt_m = '0;
    lcnt_m = '0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    rst_i = 1'b1;

    // Wait restarts from RUN: flag must take the full count again
    for (int i = 0; i < 9; i++) mem(1'b1, 1'b0, FRZ, 1'b0, "post_rst_wait");
    mem(1'b1, 1'b0, FRZ, 1'b1, "post_rst_to");
    mem(1'b1, 1'b1, NORM, 1'b1, "post_rst_ack");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
